// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/hazard control FSM that drives PC and pipeline-register enables, flushes and load-use stall count.
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned ZERO_REG    = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rd,
  input  logic [4:0]  IFID_Rn,
  input  logic [4:0]  IFID_Rm,
  input  logic        MEM_BranchTaken,
  input  logic        halt_req,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic [2:0]  state,
  output logic [31:0] stall_count
);
  typedef enum logic [2:0] {BOOT = 3'd0, RUN = 3'd1, STALL = 3'd2, FLUSH = 3'd3, HALT = 3'd4} state_t;
  state_t      state_q, state_d;
  logic [31:0] boot_cnt_q, boot_cnt_d, stall_count_q, stall_count_d;
  logic        hazard, act, br, hl, st, boot_done;
  assign hazard = IDEX_MemRead && IDEX_Rd != 5'(ZERO_REG) && (IDEX_Rd == IFID_Rn || IDEX_Rd == IFID_Rm);
  always_comb begin
    act           = state_q == RUN || state_q == STALL || state_q == FLUSH;
    br            = act && MEM_BranchTaken;
    hl            = act && !br && halt_req;
    // hazard is only honoured in RUN; STALL and FLUSH mask it
    st            = state_q == RUN && !br && !hl && hazard;
    PCWrite       = act && !hl && !st;
    IFIDWrite     = act && !hl && !st;
    PCSrc         = br;
    IFIDFlush     = br;
    IDEXFlush     = br || st;
    EXMEMFlush    = br;
    boot_done     = boot_cnt_q + 32'd1 >= 32'(BOOT_CYCLES);
    boot_cnt_d    = state_q == BOOT ? boot_cnt_q + 32'd1 : boot_cnt_q;
    state_d       = state_q == BOOT ? (boot_done ? RUN : BOOT) :
                    act ? (br ? FLUSH : hl ? HALT : st ? STALL : RUN) :
                    state_q == HALT ? HALT : RUN;
    stall_count_d = st && stall_count_q != '1 ? stall_count_q + 32'd1 : stall_count_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      boot_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign state       = state_q;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table plus hand sequences for boot, hazards, branches, halt, async reset and saturation.
module tb_fetch_sequencer;
  logic        clk, reset, IDEX_MemRead, MEM_BranchTaken, halt_req;
  logic [4:0]  IDEX_Rd, IFID_Rn, IFID_Rm;
  logic        PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush;
  logic [2:0]  state;
  logic [31:0] stall_count;
  int          n_cmp = 0, n_err = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
    .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .MEM_BranchTaken(MEM_BranchTaken),
    .halt_req(halt_req), .PCWrite(PCWrite), .PCSrc(PCSrc), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
    .state(state), .stall_count(stall_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic [4:0]  rd, rn, rm;
    logic        br, hr;
    logic [5:0]  ctl;
    logic [2:0]  st;
    logic [31:0] sc;
  } vec_t;

  // ctl = {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush}
  localparam logic [5:0] OFF = 6'b000000, RUNC = 6'b101000, STALLC = 6'b000010, BRC = 6'b111111;

  vec_t sb[$];
  vec_t tbl[15];

  function automatic vec_t mk(logic mr, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                              logic br, logic hr, logic [5:0] ctl, logic [2:0] st, logic [31:0] sc);
    vec_t v;
    v.mr = mr; v.rd = rd; v.rn = rn; v.rm = rm; v.br = br; v.hr = hr;
    v.ctl = ctl; v.st = st; v.sc = sc;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IDEX_MemRead = v.mr; IDEX_Rd = v.rd; IFID_Rn = v.rn; IFID_Rm = v.rm;
    MEM_BranchTaken = v.br; halt_req = v.hr;
  endtask

  // called one time unit after a rising edge; returns at the same phase of the next cycle
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " ctl"}, 32'(ctl_now()), 32'(e.ctl));
    chk({tag, " state"}, 32'(state), 32'(e.st));
    chk({tag, " stall_count"}, stall_count, e.sc);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1;
    #1;
    chk({tag, " rst state"}, 32'(state), 32'd0);
    chk({tag, " rst ctl"}, 32'(ctl_now()), 32'd0);
    chk({tag, " rst stall_count"}, stall_count, 32'd0);
    @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    reset = 1;
    drive(mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    tbl[0]  = mk(1, 5, 5, 5, 1, 1, OFF, 0, 0);
    tbl[1]  = mk(1, 5, 5, 5, 0, 0, OFF, 0, 0);
    tbl[2]  = mk(0, 0, 1, 2, 0, 0, RUNC, 1, 0);
    tbl[3]  = mk(1, 5, 1, 5, 0, 0, STALLC, 1, 0);
    tbl[4]  = mk(1, 5, 1, 5, 0, 0, RUNC, 2, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, RUNC, 1, 1);
    tbl[6]  = mk(1, 31, 31, 2, 0, 0, RUNC, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, RUNC, 1, 1);
    tbl[8]  = mk(1, 7, 7, 0, 1, 0, BRC, 1, 1);
    tbl[9]  = mk(1, 7, 7, 0, 0, 0, RUNC, 3, 1);
    tbl[10] = mk(1, 9, 0, 9, 0, 0, STALLC, 1, 1);
    tbl[11] = mk(1, 9, 0, 9, 1, 0, BRC, 2, 2);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, OFF, 3, 2);
    tbl[13] = mk(1, 4, 4, 4, 1, 1, OFF, 4, 2);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, OFF, 4, 2);

    @(posedge clk);
    #1;
    chk("hold state", 32'(state), 32'd0);
    chk("hold ctl", 32'(ctl_now()), 32'd0);
    chk("hold stall_count", stall_count, 32'd0);
    reset = 0;
    for (int i = 0; i < 15; i++) step($sformatf("tbl%0d", i), tbl[i]);

    async_reset("halt");
    step("h_boot0", mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    step("h_boot1", mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    step("h_halt", mk(0, 0, 0, 0, 0, 1, OFF, 1, 0));
    step("h_br", mk(0, 0, 0, 0, 1, 0, OFF, 4, 0));

    async_reset("pre");
    step("s_boot0", mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    step("s_boot1", mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    step("s_haz", mk(1, 3, 3, 0, 0, 0, STALLC, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    async_reset("stall");
    step("s_boot2", mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    step("s_boot3", mk(0, 0, 0, 0, 0, 0, OFF, 0, 0));
    step("s_run", mk(0, 0, 0, 0, 0, 0, RUNC, 1, 0));

    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1 release dut.stall_count_q;
    step("sat_haz", mk(1, 8, 0, 8, 0, 0, STALLC, 1, 32'hFFFF_FFFF));
    step("sat_stall", mk(0, 0, 0, 0, 0, 0, RUNC, 2, 32'hFFFF_FFFF));
    step("sat_run", mk(0, 0, 0, 0, 0, 0, RUNC, 1, 32'hFFFF_FFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: BOOT_CYCLES, default 2, number of cycles fetch is held off after reset.
REQ-002 Parameter: ZERO_REG, default 31, register index never treated as a hazard destination (XZR).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: IDEX_MemRead  input  1  instruction in ID/EX is a load.
REQ-006 Port: IDEX_Rd  input  5  destination register of the ID/EX instruction.
REQ-007 Port: IFID_Rn  input  5  first source register of the IF/ID instruction.
REQ-008 Port: IFID_Rm  input  5  second source register of the IF/ID instruction.
REQ-009 Port: MEM_BranchTaken  input  1  branch resolved taken in MEM stage.
REQ-010 Port: halt_req  input  1  request to stop fetching.
REQ-011 Port: PCWrite  output  1  program counter update enable.
REQ-012 Port: PCSrc  output  1  PC mux select; 1 = branch target, 0 = PC+4.
REQ-013 Port: IFIDWrite  output  1  IF/ID register load enable.
REQ-014 Port: IFIDFlush, IDEXFlush, EXMEMFlush  output  1 each  clear the respective pipeline register to a bubble.
REQ-015 Port: state  output  3  current FSM state encoding.
REQ-016 Port: stall_count  output  32  count of load-use stall cycles.

Function
REQ-017 FSM states SHALL be BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4; other encodings SHALL go to RUN on the next edge.
REQ-018 Hazard term SHALL be IDEX_MemRead and IDEX_Rd != ZERO_REG and (IDEX_Rd == IFID_Rn or IDEX_Rd == IFID_Rm).
REQ-019 Control outputs SHALL be combinational from state and current inputs (Mealy); state and stall_count SHALL be registered.
REQ-020 BOOT: all control outputs 0; an internal counter SHALL advance each cycle; after exactly BOOT_CYCLES cycles in BOOT, next state RUN (BOOT_CYCLES=0 means RUN on the first edge after reset release).
REQ-021 RUN/STALL/FLUSH default outputs: PCWrite=1, IFIDWrite=1, PCSrc=0, all flushes 0.
REQ-022 Priority in RUN/STALL/FLUSH SHALL be MEM_BranchTaken > halt_req > hazard.
REQ-023 MEM_BranchTaken=1 in RUN, STALL or FLUSH: same cycle PCSrc=1, PCWrite=1, IFIDFlush=IDEXFlush=EXMEMFlush=1; next state FLUSH.
REQ-024 halt_req=1 (no branch) in RUN, STALL or FLUSH: same cycle PCWrite=0, IFIDWrite=0; next state HALT.
REQ-025 Hazard in RUN (no branch, no halt): same cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; stall_count increments; next state STALL.
REQ-026 STALL and FLUSH SHALL last one cycle, mask the hazard term, and return to RUN absent branch or halt.
REQ-027 HALT: PCWrite=0, IFIDWrite=0, all flushes and PCSrc 0; MEM_BranchTaken and halt_req ignored; exit only via reset.
REQ-028 In BOOT, MEM_BranchTaken, halt_req and the hazard term SHALL be ignored.
REQ-029 stall_count SHALL saturate at 0xFFFFFFFF and never wrap.

Reset
REQ-030 reset assertion SHALL immediately, independent of clk, force state=BOOT, boot counter=0, stall_count=0, all control outputs 0.
REQ-031 reset asserted mid-stall, mid-flush or in HALT SHALL abort that operation with no residual effect after release.

Verification
REQ-032 Reset release, default params -> state=BOOT for 2 edges, PCWrite=0; third cycle state=RUN, PCWrite=1, IFIDWrite=1.
REQ-033 RUN, IDEX_MemRead=1, IDEX_Rd=5, IFID_Rm=5 held 2 cycles -> cycle 1 PCWrite=0, IDEXFlush=1; cycle 2 state=STALL, PCWrite=1; stall_count=1.
REQ-034 RUN, hazard with IDEX_Rd=31=IFID_Rn -> no stall, PCWrite=1, stall_count unchanged.
REQ-035 RUN, hazard and MEM_BranchTaken same cycle -> PCSrc=1, three flushes=1, stall_count unchanged, next state FLUSH then RUN.
REQ-036 halt_req=1 in RUN -> PCWrite=0 same cycle, state=HALT next edge; later MEM_BranchTaken=1 -> PCSrc stays 0; reset -> BOOT.
REQ-037 stall_count preloaded to 0xFFFFFFFF via forced stalls -> further hazard stall leaves it at 0xFFFFFFFF.
